batch_job_sequencer: RTL and testbench

- Synthesizable, parametrised controller that runs a batch of jobs on a processing core using that core's start/finish/file_index handshake.
- Issues one start pulse per job, waits for the core's finish, then advances file_index until job_count jobs have completed.
- Adds runtime batch size and base index, configurable start-pulse width, a finish-timeout watchdog with skip/abort policy, abort input, and completion/error reporting.
- Sits between the top-level control (or bench) and the core's `main` interface.

---
 rtl/batch_job_sequencer.sv | 117 +++++++++++
 tb/tb_batch_job_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/batch_job_sequencer.sv
// batch_job_sequencer: runs a batch of start/finish jobs on a core with watchdog, abort and reporting
module batch_job_sequencer #(
  parameter int IDX_W = 10,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT_W = 20,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SKIP_ON_TIMEOUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [IDX_W-1:0] first_index,
  input  logic [IDX_W-1:0] job_count,
  input  logic             abort,
  input  logic             finish,
  output logic             start,
  output logic [IDX_W-1:0] file_index,
  output logic             busy,
  output logic             batch_done,
  output logic [IDX_W-1:0] jobs_done,
  output logic             timeout_err,
  output logic [IDX_W-1:0] err_index
);
  localparam int SC_W = $clog2(START_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_END = SC_W'(START_CYCLES);
  localparam logic [TIMEOUT_W-1:0] WD_END = TIMEOUT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, START, WAIT_FIN, GAP, DONE} state_t;
  state_t state, state_n;
  logic [SC_W-1:0] sc, sc_n;
  logic [TIMEOUT_W-1:0] wd, wd_n;
  logic armed, armed_n, terr_n, zero_n, accept, tmo, adv;
  logic [IDX_W-1:0] count, count_n, idx_n, done_n, eidx_n;
  // next-state and datapath; START spends one quiet cycle before raising start, so finish gets a chance to drop
  always_comb begin
    accept = state == WAIT_FIN && armed && finish;
    tmo = state == WAIT_FIN && !accept && TIMEOUT_CYCLES != 0 && wd == WD_END;
    adv = accept || (tmo && SKIP_ON_TIMEOUT != 0);
    state_n = state;
    sc_n = sc;
    wd_n = wd;
    count_n = count;
    idx_n = file_index;
    done_n = jobs_done;
    terr_n = timeout_err;
    eidx_n = err_index;
    zero_n = 1'b0;
    if (abort && state != IDLE) state_n = IDLE;
    else case (state)
      IDLE: if (go) begin
        if (job_count != '0) begin
          state_n = START;
          sc_n = '0;
          count_n = job_count;
          idx_n = first_index;
          done_n = '0;
          terr_n = 1'b0;
        end else zero_n = 1'b1;
      end
      START: if (sc == SC_END) begin
        state_n = WAIT_FIN;
        wd_n = '0;
      end else sc_n = sc + 1'b1;
      WAIT_FIN: begin
        wd_n = wd + 1'b1;
        if (tmo) begin
          terr_n = 1'b1;
          eidx_n = file_index;
        end
        if (adv) begin
          done_n = jobs_done + 1'b1;
          if (done_n == count) state_n = DONE;
          else begin
            idx_n = file_index + 1'b1;
            state_n = GAP;
          end
        end else if (tmo) state_n = DONE;
      end
      GAP: begin
        state_n = START;
        sc_n = '0;
      end
      default: state_n = IDLE;
    endcase
    armed_n = (state_n == START && state != START) ? 1'b0 :
              ((state == START || state == WAIT_FIN) && !finish) ? 1'b1 : armed;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sc <= '0;
      wd <= '0;
      armed <= 1'b0;
      count <= '0;
      file_index <= '0;
      jobs_done <= '0;
      timeout_err <= 1'b0;
      err_index <= '0;
      start <= 1'b0;
      busy <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      state <= state_n;
      sc <= sc_n;
      wd <= wd_n;
      armed <= armed_n;
      count <= count_n;
      file_index <= idx_n;
      jobs_done <= done_n;
      timeout_err <= terr_n;
      err_index <= eidx_n;
      start <= state_n == START && sc_n != '0;
      busy <= state_n != IDLE;
      batch_done <= state_n == DONE || zero_n;
    end
  end
endmodule

// File: tb/tb_batch_job_sequencer.sv
// tb_batch_job_sequencer: directed bench for batch_job_sequencer (skip and abort-on-timeout instances)
module tb_batch_job_sequencer;
  logic clk = 0, rst = 1, go = 0, abort = 0;
  logic [3:0] first_index = 0, job_count = 0;
  logic start [2], busy [2], batch_done [2], timeout_err [2], finish [2];
  logic [3:0] file_index [2], jobs_done [2], err_index [2];
  logic sticky_en = 0, sticky_val = 0, never_en = 0;
  logic [3:0] never_idx = 0;
  int checks = 0, errors = 0;
  int n_start [2], n_done [2], bad_w [2], w [2], nlog = 0;
  bit sp [2];
  logic [3:0] log0 [64];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic cf = 0, ps = 0, pend = 0;
    int cnt = 0;
    batch_job_sequencer #(.IDX_W(4), .START_CYCLES(2), .TIMEOUT_W(8), .TIMEOUT_CYCLES(50),
      .SKIP_ON_TIMEOUT(g == 0 ? 1 : 0)) dut (.clk(clk), .rst(rst), .go(go), .first_index(first_index),
      .job_count(job_count), .abort(abort), .finish(finish[g]), .start(start[g]), .file_index(file_index[g]),
      .busy(busy[g]), .batch_done(batch_done[g]), .jobs_done(jobs_done[g]), .timeout_err(timeout_err[g]),
      .err_index(err_index[g]));
    assign finish[g] = sticky_en ? sticky_val : cf;
    always @(posedge clk) begin
      ps <= start[g];
      if (rst || start[g]) begin
        cf <= 0;
        pend <= 0;
      end else if (ps) begin
        pend <= !(never_en && file_index[g] == never_idx);
        cnt <= 1;
      end else if (pend) begin
        if (cnt == 10) begin
          cf <= 1;
          pend <= 0;
        end
        cnt <= cnt + 1;
      end
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (start[k] === 1'b1 && !sp[k]) begin
        n_start[k]++;
        if (k == 0 && nlog < 64) begin
          log0[nlog] = file_index[0];
          nlog++;
        end
      end
      if (start[k] === 1'b1) w[k]++;
      else if (sp[k]) begin
        if (w[k] != 2) bad_w[k]++;
        w[k] = 0;
      end
      if (batch_done[k] === 1'b1) n_done[k]++;
      sp[k] = start[k] === 1'b1;
    end
  end
  task automatic start_batch(input logic [3:0] f, input logic [3:0] c);
    first_index = f;
    job_count = c;
    go = 1;
    @(negedge clk);
    go = 0;
  endtask
  task automatic wait_idle(input int budget, input string nm);
    int n;
    for (n = 0; n < budget && (busy[0] !== 1'b0 || busy[1] !== 1'b0); n++) @(negedge clk);
    checks++;
    if (n == budget) begin errors++; $display("FAIL %s_end busy still high after %0d cycles", nm, budget); end
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({start[k], busy[k], batch_done[k], timeout_err[k], file_index[k], jobs_done[k], err_index[k]} !== 16'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got %h want 0", k, {start[k], busy[k], batch_done[k], timeout_err[k], file_index[k], jobs_done[k], err_index[k]});
      end
    end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_basic;
    int s0 = n_start[0], d0 = n_done[0], b0 = bad_w[0], l0 = nlog;
    start_batch(0, 3);
    checks++; if ({busy[0], start[0]} !== 2'b10) begin errors++; $display("FAIL lat_first got %b want 10", {busy[0], start[0]}); end
    @(negedge clk);
    checks++; if (start[0] !== 1'b1) begin errors++; $display("FAIL lat_start1 got %b want 1", start[0]); end
    @(negedge clk);
    checks++; if (start[0] !== 1'b1) begin errors++; $display("FAIL lat_start2 got %b want 1", start[0]); end
    @(negedge clk);
    checks++; if (start[0] !== 1'b0) begin errors++; $display("FAIL lat_wait got %b want 0", start[0]); end
    wait_idle(500, "basic");
    checks++; if (n_start[0] - s0 != 3) begin errors++; $display("FAIL basic_starts got %0d want 3", n_start[0] - s0); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (log0[l0 + i] !== 4'(i)) begin errors++; $display("FAIL basic_idx%0d got %0d want %0d", i, log0[l0 + i], i); end
    end
    checks++; if (bad_w[0] != b0) begin errors++; $display("FAIL basic_width got %0d bad pulses want 0", bad_w[0] - b0); end
    checks++; if (jobs_done[0] !== 4'd3) begin errors++; $display("FAIL basic_jobs got %0d want 3", jobs_done[0]); end
    checks++; if (n_done[0] - d0 != 1) begin errors++; $display("FAIL basic_done got %0d want 1", n_done[0] - d0); end
    checks++; if (timeout_err[0] !== 1'b0) begin errors++; $display("FAIL basic_terr got %b want 0", timeout_err[0]); end
    checks++; if (file_index[0] !== 4'd2) begin errors++; $display("FAIL basic_hold_idx got %0d want 2", file_index[0]); end
  endtask
  task automatic test_sticky;
    int n, d0 = n_done[0];
    start_batch(5, 3);
    for (n = 0; n < 200 && file_index[0] !== 4'd6; n++) @(negedge clk);
    checks++; if (n == 200) begin errors++; $display("FAIL sticky_reach_job1 got idx %0d want 6", file_index[0]); end
    sticky_en = 1;
    sticky_val = 1;
    for (n = 0; n < 10 && start[0] !== 1'b1; n++) @(negedge clk);
    for (n = 0; n < 10 && start[0] !== 1'b0; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++; if ({busy[0], jobs_done[0]} !== 5'h11) begin errors++; $display("FAIL sticky_held got busy %b jobs %0d want 1 1", busy[0], jobs_done[0]); end
    sticky_val = 0;
    @(negedge clk);
    checks++; if (jobs_done[0] !== 4'd1) begin errors++; $display("FAIL sticky_low got %0d want 1", jobs_done[0]); end
    sticky_val = 1;
    @(negedge clk);
    checks++; if ({jobs_done[0], file_index[0]} !== 8'h27) begin errors++; $display("FAIL sticky_accept got jobs %0d idx %0d want 2 7", jobs_done[0], file_index[0]); end
    sticky_en = 0;
    wait_idle(400, "sticky");
    checks++; if (jobs_done[0] !== 4'd3) begin errors++; $display("FAIL sticky_jobs got %0d want 3", jobs_done[0]); end
    checks++; if (timeout_err[0] !== 1'b0) begin errors++; $display("FAIL sticky_terr got %b want 0", timeout_err[0]); end
    checks++; if (n_done[0] - d0 != 1) begin errors++; $display("FAIL sticky_done got %0d want 1", n_done[0] - d0); end
  endtask
  task automatic test_timeout;
    int d0 = n_done[0], d1 = n_done[1];
    never_en = 1;
    never_idx = 1;
    start_batch(0, 3);
    wait_idle(1000, "timeout");
    never_en = 0;
    checks++; if ({timeout_err[0], err_index[0], jobs_done[0], file_index[0]} !== 13'h1132) begin
      errors++; $display("FAIL skip_result got terr %b eidx %0d jobs %0d idx %0d want 1 1 3 2", timeout_err[0], err_index[0], jobs_done[0], file_index[0]); end
    checks++; if (n_done[0] - d0 != 1) begin errors++; $display("FAIL skip_done got %0d want 1", n_done[0] - d0); end
    checks++; if ({timeout_err[1], err_index[1], jobs_done[1], file_index[1]} !== 13'h1111) begin
      errors++; $display("FAIL noskip_result got terr %b eidx %0d jobs %0d idx %0d want 1 1 1 1", timeout_err[1], err_index[1], jobs_done[1], file_index[1]); end
    checks++; if (n_done[1] - d1 != 1) begin errors++; $display("FAIL noskip_done got %0d want 1", n_done[1] - d1); end
  endtask
  task automatic test_abort;
    int n, d0;
    start_batch(0, 4);
    checks++; if ({timeout_err[0], timeout_err[1], jobs_done[0]} !== 6'd0) begin
      errors++; $display("FAIL go_clears got terr %b%b jobs %0d want 00 0", timeout_err[0], timeout_err[1], jobs_done[0]); end
    for (n = 0; n < 300 && file_index[0] !== 4'd2; n++) @(negedge clk);
    for (n = 0; n < 20 && start[0] !== 1'b1; n++) @(negedge clk);
    checks++; if (n == 20) begin errors++; $display("FAIL abort_reach_start got start %b want 1", start[0]); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    d0 = n_done[0];
    checks++; if ({start[0], busy[0], batch_done[0], jobs_done[0], file_index[0]} !== 11'h022) begin
      errors++; $display("FAIL abort_state got start %b busy %b bd %b jobs %0d idx %0d want 0 0 0 2 2", start[0], busy[0], batch_done[0], jobs_done[0], file_index[0]); end
    abort = 1;
    repeat (5) @(negedge clk);
    abort = 0;
    checks++; if ({n_done[0] == d0, start[0], busy[0], jobs_done[0]} !== 7'b1000010) begin
      errors++; $display("FAIL abort_after got done+%0d start %b busy %b jobs %0d want 0 0 0 2", n_done[0] - d0, start[0], busy[0], jobs_done[0]); end
  endtask
  task automatic test_wrap_zero;
    int s0 = n_start[0], l0 = nlog;
    logic [3:0] exp [4] = '{14, 15, 0, 1};
    start_batch(14, 4);
    repeat (3) @(negedge clk);
    start_batch(9, 1);
    wait_idle(600, "wrap");
    checks++; if (n_start[0] - s0 != 4) begin errors++; $display("FAIL wrap_starts got %0d want 4", n_start[0] - s0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (log0[l0 + i] !== exp[i]) begin errors++; $display("FAIL wrap_idx%0d got %0d want %0d", i, log0[l0 + i], exp[i]); end
    end
    checks++; if ({jobs_done[0], file_index[0]} !== 8'h41) begin errors++; $display("FAIL wrap_final got jobs %0d idx %0d want 4 1", jobs_done[0], file_index[0]); end
    s0 = n_start[0];
    start_batch(5, 0);
    checks++; if ({batch_done[0], busy[0]} !== 2'b10) begin errors++; $display("FAIL zero_pulse got bd %b busy %b want 1 0", batch_done[0], busy[0]); end
    @(negedge clk);
    checks++; if (batch_done[0] !== 1'b0) begin errors++; $display("FAIL zero_single got %b want 0", batch_done[0]); end
    repeat (4) @(negedge clk);
    checks++; if ({n_start[0] == s0, jobs_done[0], file_index[0]} !== 9'h141) begin
      errors++; $display("FAIL zero_quiet got starts+%0d jobs %0d idx %0d want 0 4 1", n_start[0] - s0, jobs_done[0], file_index[0]); end
  endtask
  task automatic test_rst_mid;
    int n;
    start_batch(3, 2);
    for (n = 0; n < 20 && start[0] !== 1'b1; n++) @(negedge clk);
    for (n = 0; n < 20 && start[0] !== 1'b0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if ({busy[0], file_index[0]} !== 5'h13) begin errors++; $display("FAIL rst_setup got busy %b idx %0d want 1 3", busy[0], file_index[0]); end
    test_reset;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_sticky;
    test_timeout;
    test_abort;
    test_wrap_zero;
    test_rst_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
